// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared constants and state type for the memory request path
//
// Purpose: default bus widths, the initiator state encoding and the segment
// base addresses that the initiator and the memory controller agree on.
// Ports: none (package).

package mem_if_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } init_state_t;

    // Segment bases, decoded only by the memory controller.
    localparam logic [DEF_ADDR_W-1:0] SEG_ROM_BASE = 10'h000;
    localparam logic [DEF_ADDR_W-1:0] SEG_RAM_BASE = 10'h100;
    localparam logic [DEF_ADDR_W-1:0] SEG_IO_BASE  = 10'h300;

endpackage

// File: rtl/mem_req_initiator.sv
// rtl/mem_req_initiator.sv - single-outstanding load/store front end for the memory controller
//
// Purpose: accepts one core request at a time, issues a one-cycle write or
// read strobe to the controller, waits RD_LATENCY cycles for read data and
// returns it over a valid/ready response channel.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (req_ready combinational)
//   req_we, req_addr, req_wdata   request payload
//   rsp_valid/rsp_ready           read response handshake
//   rsp_rdata                     read data, held while rsp_valid
//   mem_addr, mem_wdata           registered address/data to the controller
//   mem_wr_en, mem_rd_en          one-cycle strobes
//   mem_rdata                     read data from the controller
//   busy                          high whenever the FSM is not IDLE

module mem_req_initiator
    import mem_if_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    generate
        if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_latency
            $error("mem_req_initiator: RD_LATENCY must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY);

    init_state_t state;
    init_state_t state_next;
    logic [3:0]  lat_cnt;
    logic        req_fire;

    assign req_ready = (state == IDLE) && !rst;
    assign req_fire  = req_valid && req_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_fire) state_next = req_we ? WRITE : READ;
            WRITE:   state_next = IDLE;
            READ:    state_next = WAIT;
            WAIT:    if (lat_cnt == 4'd1) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            lat_cnt   <= '0;
            busy      <= 1'b0;
        end else begin
            state <= state_next;
            // Strobes and status are registered from the next state so each
            // one lines up exactly with the cycle spent in that state.
            mem_wr_en <= (state_next == WRITE);
            mem_rd_en <= (state_next == READ);
            rsp_valid <= (state_next == RESP);
            busy      <= (state_next != IDLE);

            if (req_fire) begin
                mem_addr <= req_addr;
                if (req_we) begin
                    mem_wdata <= req_wdata;
                end
            end

            if (state == READ) begin
                lat_cnt <= LAT_INIT;
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - 4'd1;
                // Last wait cycle is the RD_LATENCY-th cycle after the strobe.
                if (lat_cnt == 4'd1) begin
                    rsp_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: doc/mem_req_initiator.md
Name: mem_req_initiator

Overview:
Requester-side front end for the memory controller. It accepts single load/store requests from the core over a valid/ready handshake. It drives the controller's wr_en/rd_en/addr/data interface with one-cycle strobes. It waits a fixed read latency, then returns read data over a valid/ready response channel. At most one transaction is in flight at any time.

Parameters:
ADDR_W, 10, word address width; matches the controller's addr port.
DATA_W, 32, data width.
RD_LATENCY, 1, cycles from the mem_rd_en cycle to valid mem_rdata; legal range 1..15; elaboration error outside this range.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous active-high reset.
req_valid  in  1  core request valid.
req_ready  out  1  initiator can accept a request.
req_we  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  word address.
req_wdata  in  DATA_W  write data.
rsp_valid  out  1  read data valid.
rsp_ready  in  1  core accepts the response.
rsp_rdata  out  DATA_W  read data.
mem_addr  out  ADDR_W  address to the memory controller.
mem_wdata  out  DATA_W  write data to the memory controller.
mem_wr_en  out  1  write strobe.
mem_rd_en  out  1  read strobe.
mem_rdata  in  DATA_W  read data from the memory controller.
busy  out  1  high when state != IDLE.

Behaviour:
- Reset (sync, rst high at a rising edge):
  - state = IDLE.
  - mem_addr = 0, mem_wdata = 0, mem_wr_en = 0, mem_rd_en = 0.
  - rsp_valid = 0, rsp_rdata = 0, latency counter = 0.
  - req_ready = 0 while rst is high.
- Outputs:
  - req_ready = (state == IDLE) && !rst, combinational.
  - All other outputs are registered.
- States: IDLE, WRITE, READ, WAIT, RESP.
- IDLE:
  - On req_valid && req_ready, register req_addr into mem_addr; for writes also register req_wdata into mem_wdata.
  - Next state is WRITE if req_we, else READ.
  - Otherwise stay in IDLE.
- WRITE:
  - mem_wr_en = 1 for exactly this cycle.
  - Next state IDLE. No response is generated for writes.
- READ:
  - mem_rd_en = 1 for exactly this cycle; counter loaded with RD_LATENCY.
  - Next state WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 1, capture mem_rdata into rsp_rdata; next state RESP.
  - So mem_rdata is sampled at the end of the cycle RD_LATENCY cycles after the mem_rd_en cycle.
- RESP:
  - rsp_valid = 1; rsp_rdata is held stable.
  - On rsp_ready, next state IDLE and rsp_valid falls next cycle.
  - rsp_ready already high in the first RESP cycle completes the handshake in that cycle.
- Latency, request accepted at edge N:
  - Write: mem_wr_en high in cycle N+1; req_ready high again in cycle N+2.
  - Read: mem_rd_en high in cycle N+1; rsp_valid high in cycle N+2+RD_LATENCY.
  - Back-to-back throughput: one write per 2 cycles; one read per RD_LATENCY+3 cycles minimum.
- Invariants:
  - mem_wr_en and mem_rd_en are never high together.
  - Each strobe is high for exactly one cycle per transaction.
  - mem_addr and mem_wdata hold their last value between transactions.
  - mem_wdata is not updated by reads.
- Address handling:
  - Full range 0..2^ADDR_W-1 is passed through untouched; 0x3FF is legal.
  - No range check and no wrap arithmetic; segment decode belongs to the controller.
- Request channel while busy: req_valid is ignored; the core must hold its request until req_ready.
- Reset mid-operation:
  - Aborts immediately; strobes drop at the next edge.
  - No response is issued.
  - A pending read's data is discarded.

Decomposition:
- Package mem_if_pkg:
  - ADDR_W and DATA_W default constants.
  - typedef enum logic [2:0] for the state: IDLE, WRITE, READ, WAIT, RESP.
  - Segment base-address constants shared with the memory controller.
- No sub-module. The latency counter and response register are small enough to stay inline.

Test Plan:
1. Reset: rst high 2 cycles with random inputs -> all outputs 0; req_ready = 1 first cycle after rst falls.
2. Write: req_we = 1, addr = 0x3FF, wdata = 0x25 accepted at N -> cycle N+1 mem_wr_en = 1, mem_addr = 0x3FF, mem_wdata = 0x25, mem_rd_en = 0; cycle N+2 req_ready = 1; rsp_valid never asserts.
3. Read, RD_LATENCY = 1: addr = 0x000; model returns 0xDEADBEEF one cycle after mem_rd_en -> mem_rd_en in N+1 only; rsp_valid = 1, rsp_rdata = 0xDEADBEEF in N+3.
4. Read, RD_LATENCY = 4: repeat scenario 3 with the latency-4 model -> rsp_valid in N+6. Then hold rsp_ready = 0 for 3 cycles -> rsp_valid and rsp_rdata stay stable; IDLE the cycle after rsp_ready = 1.
5. Back-to-back: write 0x11 to 0x005, then read 0x005, with req_valid held high -> second request accepted exactly 2 cycles after the first; read returns 0x11; no strobe overlap.
6. Mid-read reset: rst pulsed during WAIT -> strobes 0 next cycle, rsp_valid never asserts, and a new request is accepted the cycle after rst falls.
